// File: rtl/adder_arbiter.sv
// Two-requester round-robin arbiter feeding one CHUNK_W-bit adder slice that builds a
// 64-bit sum over N = 64/CHUNK_W cycles. Define ADDER_CARRY_OUT_EN to expose the final carry.
module adder_arbiter #(
   parameter int CHUNK_W = 16
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic [1:0]  req_valid_i,
   output logic [1:0]  req_ready_o,
   input  logic [63:0] num1_a_i,
   input  logic [63:0] num2_a_i,
   input  logic [63:0] num1_b_i,
   input  logic [63:0] num2_b_i,
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic        rsp_id_o,
   output logic [63:0] sum_o,
   output logic        carry_o,
   output logic        busy_o
);
   localparam int N = 64 / CHUNK_W;

   typedef enum logic [1:0] {IDLE, CALC, RESP} state_e;

   state_e        state_q, state_d;
   logic [63:0]   a_q, a_d, b_q, b_d, sum_q, sum_d;
   logic          carry_q, carry_d;
   logic [3:0]    idx_q, idx_d;
   logic          id_q, id_d, last_q, last_d;
   logic          grant;
   logic          last_slice;
   logic [31:0]   off;
   logic [CHUNK_W-1:0] sl_a, sl_b, sl_s;
   logic          sl_co;

   // Shared slice adder, walking from the least significant slice upward.
   assign off        = 32'(idx_q) * 32'(CHUNK_W);
   assign sl_a       = a_q[off +: CHUNK_W];
   assign sl_b       = b_q[off +: CHUNK_W];
   assign {sl_co, sl_s} = {1'b0, sl_a} + {1'b0, sl_b} + (CHUNK_W+1)'(carry_q);
   assign last_slice = (idx_q == 4'(N-1));

   // On a tie the requester that was not served last wins.
   always_comb begin
      grant = 1'b0;
      case (req_valid_i)
         2'b10:   grant = 1'b1;
         2'b11:   grant = ~last_q;
         default: grant = 1'b0;
      endcase
   end

   // Ready is also masked by reset so nothing looks accepted while held in reset.
   assign req_ready_o = (state_q == IDLE && rst_ni && |req_valid_i) ?
                        (grant ? 2'b10 : 2'b01) : 2'b00;

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      idx_d   = idx_q;
      id_d    = id_q;
      last_d  = last_q;
      case (state_q)
         IDLE: begin
            if (|req_ready_o) begin
               a_d     = grant ? num1_b_i : num1_a_i;
               b_d     = grant ? num2_b_i : num2_a_i;
               id_d    = grant;
               carry_d = 1'b0;
               idx_d   = '0;
               state_d = CALC;
            end
         end
         CALC: begin
            sum_d[off +: CHUNK_W] = sl_s;
            carry_d = sl_co;
            idx_d   = idx_q + 4'd1;
            if (last_slice) state_d = RESP;
         end
         RESP: begin
            if (rsp_ready_i) begin
               last_d  = id_q;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         idx_q   <= '0;
         id_q    <= 1'b0;
         last_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         idx_q   <= idx_d;
         id_q    <= id_d;
         last_q  <= last_d;
      end
   end

`ifdef ADDER_CARRY_OUT_EN
   logic cout_q;
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)                            cout_q <= 1'b0;
      else if (state_q == CALC && last_slice) cout_q <= sl_co;
   end
   assign carry_o = cout_q;
`else
   assign carry_o = 1'b0;
`endif

   assign rsp_valid_o = (state_q == RESP);
   assign busy_o      = (state_q != IDLE);
   assign rsp_id_o    = id_q;
   assign sum_o       = sum_q;
endmodule

// File: tb/tb_adder_arbiter.sv
// Randomized self-checking bench for adder_arbiter against a plain-arithmetic model.
module tb_adder_arbiter;
   localparam int CHUNK_W = 16;
   localparam int N = 64 / CHUNK_W;

   logic        clk = 1'b0;
   logic        rst_ni;
   logic [1:0]  req_valid_i;
   logic [1:0]  req_ready_o;
   logic [63:0] num1_a_i, num2_a_i, num1_b_i, num2_b_i;
   logic        rsp_valid_o, rsp_ready_i, rsp_id_o, carry_o, busy_o;
   logic [63:0] sum_o;

   int checks = 0;
   int errors = 0;
   logic exp_last;  // model: requester served most recently

   adder_arbiter #(.CHUNK_W(CHUNK_W)) dut (
      .clk_i(clk), .rst_ni(rst_ni),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .num1_a_i(num1_a_i), .num2_a_i(num2_a_i),
      .num1_b_i(num1_b_i), .num2_b_i(num2_b_i),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
      .rsp_id_o(rsp_id_o), .sum_o(sum_o), .carry_o(carry_o), .busy_o(busy_o)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // One full transaction: arbitrate, compute, hold under backpressure, hand off.
   task automatic test_op(input logic [1:0] v, input logic [63:0] a0, b0, a1, b1,
                          input int bp, input string tag);
      logic        g;
      logic [64:0] full;
      logic [1:0]  exp_rdy;
      logic        exp_c;
      int          lat;
      logic [63:0] s0;
      g = (v == 2'b01) ? 1'b0 : (v == 2'b10) ? 1'b1 : ~exp_last;
      full = g ? ({1'b0, a1} + {1'b0, b1}) : ({1'b0, a0} + {1'b0, b0});
`ifdef ADDER_CARRY_OUT_EN
      exp_c = full[64];
`else
      exp_c = 1'b0;
`endif
      exp_rdy = g ? 2'b10 : 2'b01;
      req_valid_i = v; num1_a_i = a0; num2_a_i = b0; num1_b_i = a1; num2_b_i = b1;
      rsp_ready_i = 1'b0;
      #1;
      checks++;
      if (req_ready_o !== exp_rdy) begin
         errors++; $display("FAIL %s grant: got %b want %b", tag, req_ready_o, exp_rdy);
      end
      @(posedge clk); #1;
      // Operand changes after accept must not matter.
      num1_a_i = {$urandom, $urandom}; num2_a_i = {$urandom, $urandom};
      num1_b_i = {$urandom, $urandom}; num2_b_i = {$urandom, $urandom};
      lat = 0;
      while (!rsp_valid_o && lat < 20) begin
         @(posedge clk); #1; lat++;
      end
      checks++;
      if (lat !== N) begin
         errors++; $display("FAIL %s latency: got %0d want %0d", tag, lat, N);
      end
      checks++;
      if (sum_o !== full[63:0] || rsp_id_o !== g || carry_o !== exp_c) begin
         errors++;
         $display("FAIL %s result: sum %h id %b c %b want sum %h id %b c %b",
                  tag, sum_o, rsp_id_o, carry_o, full[63:0], g, exp_c);
      end
      s0 = sum_o;
      for (int i = 0; i < bp; i++) begin
         @(posedge clk); #1;
         checks++;
         if (rsp_valid_o !== 1'b1 || sum_o !== s0 || rsp_id_o !== g || carry_o !== exp_c ||
             req_ready_o !== 2'b00 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL %s hold cycle %0d: vld %b sum %h id %b c %b rdy %b busy %b",
                     tag, i, rsp_valid_o, sum_o, rsp_id_o, carry_o, req_ready_o, busy_o);
         end
      end
      rsp_ready_i = 1'b1;
      @(posedge clk); #1;
      rsp_ready_i = 1'b0;
      checks++;
      if (busy_o !== 1'b0 || rsp_valid_o !== 1'b0) begin
         errors++; $display("FAIL %s release: busy %b vld %b want 0 0", tag, busy_o, rsp_valid_o);
      end
      exp_last = g;
      req_valid_i = 2'b00;
   endtask

   task automatic test_reset;
      rst_ni = 1'b0; req_valid_i = 2'b11; rsp_ready_i = 1'b0;
      num1_a_i = '1; num2_a_i = '1; num1_b_i = '1; num2_b_i = '1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (req_ready_o !== 2'b00 || rsp_valid_o !== 1'b0 || sum_o !== 64'd0 ||
          busy_o !== 1'b0 || carry_o !== 1'b0 || rsp_id_o !== 1'b0) begin
         errors++;
         $display("FAIL reset: rdy %b vld %b sum %h busy %b c %b id %b",
                  req_ready_o, rsp_valid_o, sum_o, busy_o, carry_o, rsp_id_o);
      end
      req_valid_i = 2'b00;
      rst_ni = 1'b1;
      exp_last = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_round_robin;
      for (int k = 0; k < 4; k++)
         test_op(2'b11, {$urandom, $urandom}, {$urandom, $urandom},
                 {$urandom, $urandom}, {$urandom, $urandom}, 0, "round_robin");
   endtask

   task automatic test_corners;
      test_op(2'b01, 64'h0000_0000_FFFF_FFFF, 64'h1, '0, '0, 0, "slice_carry");
      test_op(2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, '0, '0, 0, "overflow");
      test_op(2'b10, '0, '0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 0, "max_b");
   endtask

   task automatic test_backpressure;
      test_op(2'b11, {$urandom, $urandom}, {$urandom, $urandom},
              {$urandom, $urandom}, {$urandom, $urandom}, 10, "backpressure");
   endtask

   task automatic test_no_grant;
      req_valid_i = 2'b01;
      #2;
      req_valid_i = 2'b00;
      @(posedge clk); #1;
      checks++;
      if (busy_o !== 1'b0) begin
         errors++; $display("FAIL no_grant: busy %b want 0", busy_o);
      end
   endtask

   task automatic test_mid_reset;
      int seen;
      req_valid_i = 2'b01; num1_a_i = 64'h1234; num2_a_i = 64'h1;
      @(posedge clk); #1;
      req_valid_i = 2'b00;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_ni = 1'b0;
      #1;
      checks++;
      if (busy_o !== 1'b0 || rsp_valid_o !== 1'b0 || req_ready_o !== 2'b00) begin
         errors++;
         $display("FAIL mid_reset abort: busy %b vld %b rdy %b", busy_o, rsp_valid_o, req_ready_o);
      end
      @(posedge clk); #1;
      rst_ni = 1'b1;
      exp_last = 1'b1;
      seen = 0;
      for (int i = 0; i < N + 4; i++) begin
         @(posedge clk); #1;
         if (rsp_valid_o === 1'b1 || busy_o === 1'b1) seen++;
      end
      checks++;
      if (seen !== 0) begin
         errors++; $display("FAIL mid_reset ghost: %0d active cycles, want 0", seen);
      end
      test_op(2'b11, 64'h10, 64'h20, 64'h30, 64'h40, 1, "after_reset");
   endtask

   task automatic test_random;
      logic [63:0] ops[4];
      for (int k = 0; k < 40; k++) begin
         for (int j = 0; j < 4; j++)
            ops[j] = ($urandom_range(0, 4) == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : {$urandom, $urandom};
         test_op(2'($urandom_range(1, 3)), ops[0], ops[1], ops[2], ops[3],
                 $urandom_range(0, 3), "random");
      end
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_corners();
      test_backpressure();
      test_no_grant();
      test_mid_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/adder_arbiter.md
ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 SHALL have parameter: CHUNK_W, 16, adder slice width in bits; legal values 8, 16, 32, 64; N = 64/CHUNK_W slice cycles.
REQ-002 SHALL have port: clk_i  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port: rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: req_valid_i  input  2  bit r = requester r has an operation pending.
REQ-005 SHALL have port: req_ready_o  output  2  bit r = operands of requester r accepted this cycle.
REQ-006 SHALL have ports: num1_a_i, num2_a_i  input  64 each  requester 0 operands; num1_b_i, num2_b_i  input  64 each  requester 1 operands.
REQ-007 SHALL have port: rsp_valid_o  output  1  result available.
REQ-008 SHALL have port: rsp_ready_i  input  1  consumer takes result.
REQ-009 SHALL have port: rsp_id_o  output  1  requester index owning the result.
REQ-010 SHALL have port: sum_o  output  64  (num1 + num2) mod 2^64.
REQ-011 SHALL have port: carry_o  output  1  carry out of bit 63.
REQ-012 SHALL have port: busy_o  output  1  high whenever state is not IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, CALC, RESP; one shared CHUNK_W-bit adder slice plus 1-bit carry register.
REQ-014 IDLE: grant = sole valid requester; both valid -> requester other than last_id; req_ready_o one-hot to grant, 00 if none valid.
REQ-015 req_ready_o SHALL be 00 in CALC and RESP.
REQ-016 On accept (valid & ready) SHALL latch both 64-bit operands and id, clear carry and slice index, go CALC; later operand changes have no effect.
REQ-017 CALC: each cycle k (0..N-1) SHALL write slice k of sum = slice k of num1 + slice k of num2 + carry; carry <= slice carry out.
REQ-018 After slice N-1 SHALL go RESP; rsp_valid_o high exactly N cycles after accept edge (4 at default).
REQ-019 RESP: rsp_valid_o, sum_o, carry_o, rsp_id_o SHALL hold stable until rsp_ready_i high on a clock edge.
REQ-020 On response handshake SHALL update last_id <= rsp_id_o and return to IDLE; next accept no earlier than following edge (throughput one op per N+2 cycles).
REQ-021 Requester deasserting req_valid_i before grant SHALL cause no state change.
REQ-022 Sum SHALL wrap modulo 2^64; bit 64 goes only to carry_o.
REQ-023 sum_o/rsp_id_o/carry_o outside RESP: hold last computed value (not guaranteed meaningful).

Reset
REQ-024 rst_ni low SHALL immediately force IDLE, req_ready_o=00, rsp_valid_o=0, sum_o=0, carry_o=0, rsp_id_o=0, busy_o=0, last_id=1 (requester 0 wins first tie).
REQ-025 Reset during CALC or RESP SHALL discard the operation; no response is ever issued for it.

Configuration
REQ-026 Macro ADDER_CARRY_OUT_EN: defined -> carry_o registered final carry in RESP; undefined -> carry_o constant 0 and no final-carry output register; sum behaviour identical both ways.

Verification
REQ-027 Reset: hold rst_ni=0 with req_valid_i=11 -> req_ready_o=00, rsp_valid_o=0, sum_o=0, busy_o=0.
REQ-028 Slice carry: req0 A=0x00000000FFFFFFFF, B=0x1, rsp_ready_i=1 -> rsp_valid_o 4 cycles after accept, sum_o=0x0000000100000000, rsp_id_o=0, carry_o=0.
REQ-029 Overflow: A=0xFFFFFFFFFFFFFFFF, B=0x1 -> sum_o=0; carry_o=1 with ADDER_CARRY_OUT_EN, 0 without.
REQ-030 Round-robin: req_valid_i=11 held from reset -> grants 0,1,0,1 in order; rsp_id_o sequence 0,1,0,1.
REQ-031 Backpressure: rsp_ready_i=0 for 10 cycles in RESP -> outputs stable, req_ready_o=00, busy_o=1; one-cycle rsp_ready_i=1 -> IDLE next edge.
REQ-032 Mid-op reset: assert rst_ni=0 two cycles into CALC, release -> IDLE, no rsp_valid_o pulse for aborted op, next request served normally.
